// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operates on operand magnitudes and applies the latched signs when the result is registered.
module seq_divider #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_LEN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_LEN-1:0] part_rem;
  logic [DATA_LEN-1:0] quo_sh;
  logic [DATA_LEN-1:0] dvs_mag;
  logic                q_neg;
  logic                r_neg;

  logic                accept;
  logic                dvd_neg;
  logic                dvs_neg;
  logic                div_zero;
  logic                sgn_ovf;
  logic                special;
  logic                last_iter;
  logic [DATA_LEN:0]   rem_sh;
  logic [DATA_LEN:0]   trial;
  logic                q_bit;
  logic [DATA_LEN-1:0] rem_nxt;
  logic [DATA_LEN-1:0] quo_nxt;

  // Two's complement negate when requested, truncated to DATA_LEN.
  function automatic logic [DATA_LEN-1:0] neg_if(input logic [DATA_LEN-1:0] v,
                                                  input logic neg);
    return neg ? ((~v) + DATA_LEN'(1)) : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    accept    = in_valid && (state == IDLE) && !flush;
    dvd_neg   = is_signed && dividend[DATA_LEN-1];
    dvs_neg   = is_signed && divisor[DATA_LEN-1];
    div_zero  = (divisor == '0);
    sgn_ovf   = is_signed && (dividend == {1'b1, {(DATA_LEN-1){1'b0}}}) && (divisor == '1);
    special   = div_zero || sgn_ovf;
    last_iter = (cnt == CNT_W'(DATA_LEN - 1));

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    rem_sh  = {part_rem, quo_sh[DATA_LEN-1]};
    trial   = rem_sh - {1'b0, dvs_mag};
    q_bit   = !trial[DATA_LEN];
    rem_nxt = q_bit ? trial[DATA_LEN-1:0] : rem_sh[DATA_LEN-1:0];
    quo_nxt = {quo_sh[DATA_LEN-2:0], q_bit};
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
        BUSY:    if (last_iter) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      part_rem  <= '0;
      quo_sh    <= '0;
      dvs_mag   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!flush) begin
      if (accept) begin
        if (special) begin
          // Divide-by-zero and signed overflow results come straight from the raw operands.
          quotient  <= div_zero ? '1 : dividend;
          remainder <= div_zero ? dividend : '0;
        end else begin
          quo_sh   <= neg_if(dividend, dvd_neg);
          dvs_mag  <= neg_if(divisor, dvs_neg);
          q_neg    <= dvd_neg ^ dvs_neg;
          r_neg    <= dvd_neg;
          part_rem <= '0;
          cnt      <= '0;
        end
      end else if (state == BUSY) begin
        part_rem <= rem_nxt;
        quo_sh   <= quo_nxt;
        cnt      <= cnt + CNT_W'(1);
        if (last_iter) begin
          quotient  <= neg_if(quo_nxt, q_neg);
          remainder <= neg_if(rem_nxt, r_neg);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an independent RV32M reference model
// fills the expected-result queue as operations are issued.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         is_signed = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  res_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  seq_divider #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t m;
    if (b == '0) begin
      m.q = '1;
      m.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = a;
      m.r = '0;
    end else if (s) begin
      m.q = W'($signed(a) / $signed(b));
      m.r = W'($signed(a) % $signed(b));
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  // Issue one operation at a negedge; returns at the negedge after the accept edge.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = number of negedges after the accept edge at which out_valid is first seen.
  task automatic wait_valid(output int lat, output bit ok, output bit rdy_low);
    lat = 0;
    ok = 1'b0;
    rdy_low = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (out_valid) begin
        lat = i;
        ok = 1'b1;
        break;
      end
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (quotient !== '0) $display("FAIL reset_quotient got %h want 0", quotient); else n_pass++;
    n_total++;
    if (remainder !== '0) $display("FAIL reset_remainder got %h want 0", remainder); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run one op, check latency, in_ready low while busy, and the scoreboard result.
  task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int exp_lat);
    int lat;
    bit ok, rdy_low;
    res_t e;
    send_op(a, b, s);
    wait_valid(lat, ok, rdy_low);
    e = sb.pop_front();
    n_total++;
    if (!ok) $display("FAIL %s_timeout got no out_valid want out_valid", name); else n_pass++;
    n_total++;
    if (lat != exp_lat) $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); else n_pass++;
    n_total++;
    if (!rdy_low) $display("FAIL %s_in_ready_busy got 1 want 0", name); else n_pass++;
    n_total++;
    if (quotient !== e.q) $display("FAIL %s_quotient got %h want %h", name, quotient, e.q); else n_pass++;
    n_total++;
    if (remainder !== e.r) $display("FAIL %s_remainder got %h want %h", name, remainder, e.r); else n_pass++;
    consume();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s_return_idle got rdy=%b vld=%b want rdy=1 vld=0", name, in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    test_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 33);
    n_total++;
    if (quotient !== 32'd14 || remainder !== 32'd2)
      $display("FAIL udiv_const got %0d r %0d want 14 r 2", quotient, remainder);
    else n_pass++;
  endtask

  task automatic test_signed();
    test_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33);
    test_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33);
  endtask

  task automatic test_div_zero();
    test_op("divz_signed", 32'd5, 32'd0, 1'b1, 1);
    test_op("divz_unsigned", 32'd5, 32'd0, 1'b0, 1);
  endtask

  task automatic test_overflow();
    test_op("ovf_signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
    test_op("ovf_unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33);
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok, rdy_low;
    res_t e;
    send_op(32'd1000, 32'd9, 1'b0);
    wait_valid(lat, ok, rdy_low);
    e = sb.pop_front();
    n_total++;
    if (!ok) $display("FAIL bp_timeout got no out_valid want out_valid"); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (quotient !== e.q || remainder !== e.r)
        $display("FAIL bp_hold got %h r %h want %h r %h", quotient, remainder, e.q, e.r);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_handshake got rdy=%b vld=%b want rdy=0 vld=1", in_ready, out_valid);
      else n_pass++;
    end
    consume();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen;
    // flush while offering operands in IDLE must block acceptance
    dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL flush_idle_block got rdy=%b want 1", in_ready); else n_pass++;

    send_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL flush_abort got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen) $display("FAIL flush_no_pulse got out_valid=1 want 0"); else n_pass++;
    test_op("after_flush_9_3", 32'd9, 32'd3, 1'b0, 33);
  endtask

  task automatic test_async_reset();
    send_op(32'd1000, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    n_total++;
    if (quotient !== '0 || remainder !== '0)
      $display("FAIL areset_data got %h r %h want 0 r 0", quotient, remainder);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL areset_ctrl got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_op("after_reset_77_7", 32'd77, 32'd7, 1'b0, 33);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok, rdy_low;
    res_t e;
    logic [W-1:0] a, b;
    logic s;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : W'($urandom >> $urandom_range(0, 28));
      s = 1'($urandom_range(0, 1));
      send_op(a, b, s);
      wait_valid(lat, ok, rdy_low);
      e = sb.pop_front();
      n_total++;
      if (!ok || quotient !== e.q || remainder !== e.r)
        $display("FAIL b2b_%0d a=%h b=%h s=%b got %h r %h want %h r %h",
                 n, a, b, s, quotient, remainder, e.q, e.r);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
